// File: rtl/adc_serial_reader.sv
// Single-conversion SPI ADC reader: CONVST pulse, conversion wait, MSB-first serial capture.
// Define ADC_AVG_EN to average 2**AVG_LOG2 conversions per reported sample.
module adc_serial_reader #(
    parameter int DATA_W      = 16,
    parameter int CONV_CYCLES = 2,
    parameter int WAIT_CYCLES = 30,
    parameter int AVG_LOG2    = 2
) (
    input  logic              clk_10MHz,
    input  logic              reset,
    input  logic              locked,
    input  logic              adc_control,
    input  logic              adc_sdo,
    output logic              adc_convst,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int SHIFT_CYCLES = 2 * DATA_W;
    localparam int CNT_MAX_A    = (CONV_CYCLES > WAIT_CYCLES) ? CONV_CYCLES : WAIT_CYCLES;
    localparam int CNT_MAX      = (CNT_MAX_A > SHIFT_CYCLES) ? CNT_MAX_A : SHIFT_CYCLES;
    localparam int CNT_W        = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYCLES - 1);

    if (DATA_W < 2 || DATA_W > 32 || CONV_CYCLES < 1 || WAIT_CYCLES < 1 || AVG_LOG2 < 1) begin : g_bad_param
        $error("adc_serial_reader: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_WAIT, S_SHIFT, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // Holds the first DATA_W-1 bits; the last bit is taken straight from adc_sdo.
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   captured;
    logic                done_entry;
    logic                convst_q, convst_d, cs_n_q, cs_n_d, sclk_q, sclk_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d, busy_q, busy_d, overrun_q, overrun_d;
`ifdef ADC_AVG_EN
    localparam int ACC_W = DATA_W + AVG_LOG2;
    logic [ACC_W-1:0]    acc_q, acc_d, sum;
    logic [AVG_LOG2-1:0] avg_cnt_q, avg_cnt_d;

    function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] s);
        return s[ACC_W-1:AVG_LOG2];
    endfunction
`endif

    always_ff @(posedge clk_10MHz) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            convst_q  <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef ADC_AVG_EN
            acc_q     <= '0;
            avg_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            convst_q  <= convst_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef ADC_AVG_EN
            acc_q     <= acc_d;
            avg_cnt_q <= avg_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (adc_control && locked) begin
                    state_d = S_CONV;
                    cnt_d   = '0;
                end
            end
            S_CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Lock loss aborts any conversion in progress.
        if (!locked) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs are registered from the next state so pins change together with the state.
    always_comb begin
        captured   = {shift_q, adc_sdo};
        shift_d    = shift_q;
        if (state_q == S_SHIFT && cnt_q[0]) begin
            shift_d = captured[DATA_W-2:0];
        end
        convst_d   = (state_d == S_CONV);
        cs_n_d     = (state_d != S_SHIFT);
        sclk_d     = (state_d == S_SHIFT) && cnt_d[0];
        busy_d     = (state_d != S_IDLE);
        overrun_d  = adc_control && locked && (state_q != S_IDLE);
        done_entry = (state_q == S_SHIFT) && (state_d == S_DONE);
        data_d     = data_q;
        valid_d    = 1'b0;
`ifdef ADC_AVG_EN
        acc_d      = acc_q;
        avg_cnt_d  = avg_cnt_q;
        sum        = acc_q + ACC_W'(captured);
        if (!locked && state_q != S_IDLE) begin
            acc_d     = '0;
            avg_cnt_d = '0;
        end else if (done_entry) begin
            if (&avg_cnt_q) begin
                data_d    = avg_trunc(sum);
                valid_d   = 1'b1;
                acc_d     = '0;
                avg_cnt_d = '0;
            end else begin
                acc_d     = sum;
                avg_cnt_d = avg_cnt_q + 1'b1;
            end
        end
`else
        if (done_entry) begin
            data_d  = captured;
            valid_d = 1'b1;
        end
`endif
    end

    assign adc_convst   = convst_q;
    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader: directed scenarios plus random strobes/lock drops,
// checked every cycle against a timeline model built from conversion offsets.
module tb_adc_serial_reader;
    localparam int DW  = 16;
    localparam int CC  = 2;
    localparam int WC  = 30;
    localparam int AL  = 2;
    localparam int SH0 = 1 + CC + WC;
    localparam int LAT = CC + WC + 2 * DW + 1;

    logic          clk_10MHz = 1'b0;
    logic          reset = 1'b1, locked = 1'b0, adc_control = 1'b0, adc_sdo = 1'b0;
    logic          adc_convst, adc_cs_n, adc_sclk, sample_valid, busy, overrun;
    logic [DW-1:0] sample_data;

    always #50 clk_10MHz = ~clk_10MHz;

    adc_serial_reader #(.DATA_W(DW), .CONV_CYCLES(CC), .WAIT_CYCLES(WC), .AVG_LOG2(AL)) dut (
        .clk_10MHz(clk_10MHz), .reset(reset), .locked(locked), .adc_control(adc_control),
        .adc_sdo(adc_sdo), .adc_convst(adc_convst), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
        .sample_data(sample_data), .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
    );

    int            checks = 0, errors = 0, cyc = 0, start_t = -1, bit_idx = 0;
    logic          prev_sclk = 1'b0;
    logic [DW-1:0] adc_word = '0, conv_word = '0, exp_data = '0;
    logic          exp_convst, exp_csn, exp_sclk, exp_valid, exp_busy, exp_ovr;
    int            acc = 0, navg = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", name, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic c);
        int   kn;
        logic busy_now;
        reset = r; locked = l; adc_control = c;
        busy_now = (start_t >= 0) && (cyc > start_t) && (cyc <= start_t + LAT);
        exp_ovr  = !r && l && c && busy_now;
        if (r) begin
            start_t = -1; exp_data = '0; acc = 0; navg = 0;
        end else if (!l && busy_now) begin
            start_t = -1; acc = 0; navg = 0;
        end else if (!busy_now && l && c) begin
            start_t = cyc; conv_word = adc_word;
        end
        kn = (start_t >= 0) ? cyc + 1 - start_t : 0;
        if (kn < 1 || kn > LAT) kn = 0;
        exp_convst = (kn >= 1) && (kn <= CC);
        exp_csn    = !((kn >= SH0) && (kn < SH0 + 2 * DW));
        exp_sclk   = !exp_csn && (((kn - SH0) % 2) == 1);
        exp_busy   = (kn != 0);
        exp_valid  = 1'b0;
        if (kn == LAT) begin
`ifdef ADC_AVG_EN
            acc  = acc + int'(conv_word);
            navg = navg + 1;
            if (navg == (1 << AL)) begin
                exp_valid = 1'b1;
                exp_data  = DW'(acc >> AL);
                acc = 0; navg = 0;
            end
`else
            exp_valid = 1'b1;
            exp_data  = conv_word;
`endif
        end
        @(posedge clk_10MHz);
        #1;
        check("convst", 32'(adc_convst), 32'(exp_convst));
        check("cs_n", 32'(adc_cs_n), 32'(exp_csn));
        check("sclk", 32'(adc_sclk), 32'(exp_sclk));
        check("busy", 32'(busy), 32'(exp_busy));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        check("valid", 32'(sample_valid), 32'(exp_valid));
        check("data", 32'(sample_data), 32'(exp_data));
        // ADC device: first bit presented at CS_N low, next bit after each SCLK fall.
        if (adc_cs_n) bit_idx = 0;
        else if (prev_sclk && !adc_sclk) bit_idx++;
        prev_sclk = adc_sclk;
        adc_sdo = (bit_idx < DW) ? conv_word[DW-1-bit_idx] : 1'b0;
        cyc++;
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (100) step(1'b0, 1'b1, 1'b0);

        adc_word = 16'hA5C3;
        step(1'b0, 1'b1, 1'b1);
        repeat (70) step(1'b0, 1'b1, 1'b0);

        step(1'b0, 1'b1, 1'b1);
        repeat (9) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        repeat (60) step(1'b0, 1'b1, 1'b0);

        adc_word = DW'($urandom);
        step(1'b0, 1'b1, 1'b1);
        repeat (39) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (30) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0);

        adc_word = DW'($urandom);
        step(1'b0, 1'b1, 1'b1);
        repeat (19) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        adc_word = DW'($urandom);
        step(1'b0, 1'b1, 1'b1);
        repeat (65) step(1'b0, 1'b1, 1'b0);
        adc_word = DW'($urandom);
        step(1'b0, 1'b1, 1'b1);
        repeat (70) step(1'b0, 1'b1, 1'b0);

`ifdef ADC_AVG_EN
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            adc_word = DW'(16 + i);
            step(1'b0, 1'b1, 1'b1);
            repeat (66) step(1'b0, 1'b1, 1'b0);
        end
`endif

        repeat (800) begin
            adc_word = DW'($urandom);
            step(1'b0, ($urandom % 60) != 0, ($urandom % 15) == 0);
        end
        repeat (70) step(1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
